// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART TX byte-path bundle for uart_tx_arbiter
//
// Groups the per-requester valid/ready byte handshake and the UART TX byte
// path into one bundle.
//   req_valid/req_data/req_last : requester -> arbiter (req_data flattened, byte i at [8i+7:8i])
//   req_ready                   : arbiter -> requester, byte moves on valid&ready
//   tx_data/tx_send             : arbiter -> UART TX
//   tx_data_ready               : UART TX -> arbiter, high while the UART is idle
// The slave modport is the arbiter's view; master is the clients'/UART's view.

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_send;
  logic                 tx_data_ready;

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_data_ready,
    output req_ready,
    output tx_data,
    output tx_send
  );

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output tx_data_ready,
    input  req_ready,
    input  tx_data,
    input  tx_send
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - per-packet round-robin arbiter sharing one UART TX byte path
//
// Shares a single UART TX byte path between NUM_REQ requesters. A requester
// that hands over a byte without req_last keeps the grant until it delivers
// its last byte. Every byte goes through SEND (one tx_send strobe),
// WAIT_ACCEPT (UART must drop tx_data_ready within ACCEPT_TO cycles) and
// WAIT_DONE (UART raises tx_data_ready again = byte completed).
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : requester handshake + UART TX byte path
//   grant_valid  : a requester currently owns the TX path
//   grant_id     : index of the owning requester
//   accept_err   : one-cycle pulse when the UART never accepted a byte
//   byte_count   : bytes completed since reset, wrapping

module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ACCEPT_TO = 16,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_arbiter_if.slave           bus,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       accept_err,
  output logic [CNT_W-1:0]           byte_count
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(ACCEPT_TO + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE
  } state_t;

  state_t           r_state;
  logic [7:0]       r_tx_data;
  logic             r_tx_send;
  logic             r_grant_valid;
  logic [ID_W-1:0]  r_grant_id;
  logic             r_accept_err;
  logic [CNT_W-1:0] r_byte_count;
  logic             r_lock;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [TO_W-1:0]  r_to_cnt;

  logic             w_cand_found;
  logic [ID_W-1:0]  w_cand_id;
  logic [ID_W-1:0]  w_scan_idx;
  logic [7:0]       w_cand_data;
  logic             w_cand_last;
  logic             w_xfer;
  logic [NUM_REQ-1:0] w_req_ready;

  // Candidate selection. While locked, only the owner (held in r_grant_id)
  // may be served. Otherwise scan from rr_ptr+1 upward with wrap; the scan
  // runs from the farthest position back to the nearest so the nearest
  // valid requester is the last one written and wins.
  always_comb begin
    w_cand_found = 1'b0;
    w_cand_id    = '0;
    w_scan_idx   = '0;
    if (r_lock) begin
      w_cand_found = bus.req_valid[r_grant_id];
      w_cand_id    = r_grant_id;
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        w_scan_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (bus.req_valid[w_scan_idx]) begin
          w_cand_found = 1'b1;
          w_cand_id    = w_scan_idx;
        end
      end
    end
  end

  assign w_cand_data = bus.req_data[{w_cand_id, 3'b000} +: 8];
  assign w_cand_last = bus.req_last[w_cand_id];

  // A byte is taken only from IDLE while the UART is idle. rst_n gating keeps
  // req_ready low during reset so no client believes a byte was accepted.
  assign w_xfer = rst_n && (r_state == ST_IDLE) && bus.tx_data_ready && w_cand_found;

  always_comb begin
    w_req_ready = '0;
    if (w_xfer) begin
      w_req_ready[w_cand_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tx_data     <= 8'h00;
      r_tx_send     <= 1'b0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_accept_err  <= 1'b0;
      r_byte_count  <= '0;
      r_lock        <= 1'b0;
      r_rr_ptr      <= ID_W'(NUM_REQ - 1);
      r_to_cnt      <= '0;
    end else begin
      r_tx_send    <= 1'b0;
      r_accept_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_tx_data     <= w_cand_data;
            r_grant_id    <= w_cand_id;
            r_grant_valid <= 1'b1;
            r_tx_send     <= 1'b1;
            r_state       <= ST_SEND;
            // Lock and pointer are committed at capture, so a later accept
            // timeout does not undo the packet's arbitration state.
            if (w_cand_last) begin
              r_lock   <= 1'b0;
              r_rr_ptr <= w_cand_id;
            end else begin
              r_lock   <= 1'b1;
            end
          end
        end

        ST_SEND: begin
          r_to_cnt <= '0;
          r_state  <= ST_WAIT_ACCEPT;
        end

        ST_WAIT_ACCEPT: begin
          if (!bus.tx_data_ready) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_to_cnt == TO_W'(ACCEPT_TO - 1)) begin
            r_accept_err  <= 1'b1;
            r_state       <= ST_IDLE;
            r_grant_valid <= r_lock;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        ST_WAIT_DONE: begin
          if (bus.tx_data_ready) begin
            r_byte_count  <= r_byte_count + 1'b1;
            r_state       <= ST_IDLE;
            r_grant_valid <= r_lock;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_send   = r_tx_send;
  assign grant_valid   = r_grant_valid;
  assign grant_id      = r_grant_id;
  assign accept_err    = r_accept_err;
  assign byte_count    = r_byte_count;

endmodule
